// File: rtl/spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// spi_txn_arbiter
//
// Shares one spi_master between NUM_REQ byte-transaction requesters. A
// round-robin arbiter picks a winner. Its tx byte and SPI mode are latched onto
// the master's din/mode. The block raises the master's start handshake and
// follows the transaction through SS. It also shadow-samples MISO on the same
// edges the master uses, so the received byte can be returned with the
// completion pulse.
//
// Optional build macro:
//   SPI_ARB_TIMEOUT_EN - aborts a transaction that has not seen SS rise within
//                        TIMEOUT_CYC cycles of grant and pulses err[winner].
//                        When undefined, err is constant 0 and the block waits
//                        for the master indefinitely.
//
// Ports:
//   clk       system clock; all flops on the rising edge
//   reset     synchronous active-low reset
//   req       level request per requester, held until its done/err
//   req_din   tx byte per requester, slice i = [8i+7:8i]
//   req_mode  SPI mode per requester, slice i = [2i+1:2i] ({CPOL,CPHA})
//   gnt       one-hot grant, high for the whole transaction
//   done      one-cycle pulse on the winner's bit at normal completion
//   err       one-cycle pulse on the winner's bit at timeout abort
//   rx_data   received byte, valid with done and held until the next grant
//   busy      high whenever the arbiter is not idle
//   m_start   spi_master start
//   m_din     spi_master din
//   m_mode    spi_master mode
//   m_ss      spi_master SS (active low)
//   m_sclk    spi_master SCLK
//   m_miso    MISO net, the same one the master samples
//
// State | meaning
// ------+--------------------------------------------------------------------
// IDLE  | no transaction; arbitrate among set req bits
// START | m_start held high until the master pulls SS low
// XFER  | SS low; shadow-shift MISO on the mode's sample edges
// FIN   | SS has risen; done/rx_data are visible this cycle, gnt already low
// GAP   | one mandatory idle cycle before the next arbitration
// -----------------------------------------------------------------------------
module spi_txn_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_din,
  input  logic [NUM_REQ*2-1:0] req_mode,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic [7:0]           rx_data,
  output logic                 busy,
  output logic                 m_start,
  output logic [7:0]           m_din,
  output logic [1:0]           m_mode,
  input  logic                 m_ss,
  input  logic                 m_sclk,
  input  logic                 m_miso
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("spi_txn_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_XFER,
    S_FIN,
    S_GAP
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [3:0]         bit_cnt, bit_cnt_nxt;
  logic [7:0]         shreg, shreg_nxt;
  logic               prev_sclk;

  logic [NUM_REQ-1:0] gnt_nxt, done_nxt, err_nxt;
  logic [7:0]         rx_nxt, m_din_nxt;
  logic [1:0]         m_mode_nxt;
  logic               m_start_nxt;

  logic               pick_vld;
  logic [PTR_W-1:0]   pick, cand;
  logic [7:0]         din_sel;
  logic [1:0]         mode_sel;
  logic [NUM_REQ-1:0] pick_oh, win_oh;

  logic               sclk_edge, lead_edge, trail_edge, sample_edge;
  logic               timeout_hit;

  assign busy = (state != S_IDLE);

  // Round-robin search: first set req starting just above the last winner.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    din_sel  = '0;
    mode_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick == PTR_W'(j)) begin
        din_sel  = req_din[j*8 +: 8];
        mode_sel = req_mode[j*2 +: 2];
      end
    end
  end

  assign pick_oh = NUM_REQ'(1) << pick;
  // rr_ptr is loaded with the winner at grant, so it doubles as the winner index.
  assign win_oh  = NUM_REQ'(1) << rr_ptr;

  // Edge classification relative to the idle clock level (CPOL): leaving the
  // idle level is the leading edge, returning to it is the trailing edge.
  assign sclk_edge   = (m_sclk != prev_sclk);
  assign lead_edge   = sclk_edge && (prev_sclk == m_mode[1]);
  assign trail_edge  = sclk_edge && (prev_sclk != m_mode[1]);
  assign sample_edge = m_mode[0] ? trail_edge : lead_edge;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = ((state == S_START) || (state == S_XFER)) &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Held at zero while idle, so it starts from zero on the grant edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state == S_IDLE) begin
      to_cnt <= '0;
    end else if ((state == S_START) || (state == S_XFER)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    gnt_nxt     = gnt;
    done_nxt    = '0;
    err_nxt     = '0;
    rx_nxt      = rx_data;
    m_start_nxt = m_start;
    m_din_nxt   = m_din;
    m_mode_nxt  = m_mode;

    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_nxt     = pick_oh;
          m_din_nxt   = din_sel;
          m_mode_nxt  = mode_sel;
          rr_nxt      = pick;
          m_start_nxt = 1'b1;
          state_nxt   = S_START;
        end
      end

      S_START: begin
        if (timeout_hit) begin
          m_start_nxt = 1'b0;
          err_nxt     = win_oh;
          gnt_nxt     = '0;
          state_nxt   = S_GAP;
        end else if (!m_ss) begin
          // Dropping start here guarantees it is low long before the master
          // finishes and could relaunch.
          m_start_nxt = 1'b0;
          bit_cnt_nxt = '0;
          shreg_nxt   = '0;
          state_nxt   = S_XFER;
        end
      end

      S_XFER: begin
        if (sample_edge && !bit_cnt[3]) begin
          shreg_nxt   = {m_miso, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 4'd1;
        end
        if (timeout_hit) begin
          m_start_nxt = 1'b0;
          err_nxt     = win_oh;
          gnt_nxt     = '0;
          state_nxt   = S_GAP;
        end else if (m_ss) begin
          // Completion outputs are registered on entry so they are visible
          // during FIN; shreg_nxt includes any sample taken this same cycle.
          rx_nxt    = shreg_nxt;
          done_nxt  = win_oh;
          gnt_nxt   = '0;
          state_nxt = S_FIN;
        end
      end

      S_FIN: begin
        state_nxt = S_GAP;
      end

      S_GAP: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      bit_cnt   <= '0;
      shreg     <= '0;
      prev_sclk <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rx_data   <= '0;
      m_start   <= 1'b0;
      m_din     <= '0;
      m_mode    <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      prev_sclk <= m_sclk;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      rx_data   <= rx_nxt;
      m_start   <= m_start_nxt;
      m_din     <= m_din_nxt;
      m_mode    <= m_mode_nxt;
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter with a behavioural spi_master/slave.
module tb_spi_txn_arbiter;

  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_din;
  logic [NUM_REQ*2-1:0] req_mode;
  logic [NUM_REQ-1:0]   gnt, done, err;
  logic [7:0]           rx_data;
  logic                 busy, m_start;
  logic [7:0]           m_din;
  logic [1:0]           m_mode;
  logic                 m_ss, m_sclk, m_miso;

  // master/slave model controls
  logic                 master_busy;
  logic                 master_hold;
  logic                 slave_fixed;
  logic [7:0]           slave_byte;

  typedef struct {
    int         idx;
    logic [7:0] rx;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_txn_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_din (req_din),
    .req_mode(req_mode),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .rx_data (rx_data),
    .busy    (busy),
    .m_start (m_start),
    .m_din   (m_din),
    .m_mode  (m_mode),
    .m_ss    (m_ss),
    .m_sclk  (m_sclk),
    .m_miso  (m_miso)
  );

  always #5 clk = ~clk;

  // Behavioural spi_master + slave: 8 bits LSB-first, SCLK half period 2 clk.
  // The slave returns slave_byte when slave_fixed, otherwise ~din.
  initial begin : master_model
    logic [1:0] mm;
    logic [7:0] sb;
    m_ss = 1'b1; m_sclk = 1'b0; m_miso = 1'b0; master_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_start === 1'b1 && !master_hold) begin
        master_busy = 1'b1;
        mm = m_mode;
        sb = slave_fixed ? slave_byte : ~m_din;
        @(posedge clk); #1;
        m_sclk = mm[1];
        m_ss   = 1'b0;
        if (!mm[0]) m_miso = sb[0];
        for (int e = 0; e < 16; e++) begin
          repeat (2) @(posedge clk);
          #1;
          m_sclk = ~m_sclk;
          if (mm[0] && (e % 2 == 0)) m_miso = sb[e/2];
          if (!mm[0] && (e % 2 == 1) && e < 15) m_miso = sb[(e+1)/2];
        end
        repeat (2) @(posedge clk);
        #1;
        m_ss = 1'b1;
        master_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (gnt !== '0) begin ok = 1'b1; break; end
      cyc++;
    end
  endtask

  task automatic wait_ss_low(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_ss === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done !== '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_tests++;
    if ({gnt, done, err, rx_data, busy, m_start, m_din, m_mode} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: gnt=%b done=%b err=%b rx=%h busy=%b start=%b din=%h mode=%b, required all zero",
               gnt, done, err, rx_data, busy, m_start, m_din, m_mode);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit   ok;
    exp_t e;
    step();
    req_din[7:0] = 8'hA5; req_mode[1:0] = 2'b00;
    slave_fixed = 1'b1; slave_byte = 8'h3C;
    req = 4'b0001;
    sb_q.push_back('{0, 8'h3C});
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_latency_early: gnt=%b required 0000", gnt); end
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0001 || m_din !== 8'hA5 || m_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b din=%h start=%b busy=%b required 0001 a5 1 1", gnt, m_din, m_start, busy);
    end
    wait_ss_low(ok);
    n_tests++;
    if (!ok || m_start !== 1'b1) begin
      n_fail++; $display("FAIL single_ss_fall: ss_seen=%0d start=%b required 1 1", ok, m_start);
    end
    @(negedge clk);
    n_tests++;
    if (m_start !== 1'b0) begin n_fail++; $display("FAIL single_start_drop: start=%b required 0", m_start); end
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_done_wait: done=%b required a pulse", done); end
    e = sb_q.pop_front();
    n_tests++;
    if (done !== (4'b0001 << e.idx) || rx_data !== e.rx || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done: done=%b rx=%h gnt=%b required %b %h 0000", done, rx_data, gnt, 4'b0001 << e.idx, e.rx);
    end
    step();
    req = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (done !== 4'b0000 || busy !== 1'b1 || rx_data !== 8'h3C) begin
      n_fail++; $display("FAIL single_gap: done=%b busy=%b rx=%h required 0000 1 3c", done, busy, rx_data);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_round_robin();
    bit   ok;
    int   gap;
    int   idx;
    exp_t e;
    reset = 1'b0; step(); step(); reset = 1'b1; step();
    slave_fixed = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_din[i*8 +: 8] = 8'h20 + 8'(i * 17);
      req_mode[i*2 +: 2] = 2'b00;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      idx = k % NUM_REQ;
      sb_q.push_back('{idx, ~(8'h20 + 8'(idx * 17))});
      wait_gnt(ok, gap);
      n_tests++;
      if (!ok || gnt !== (4'b0001 << idx) || m_din !== 8'h20 + 8'(idx * 17)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: gnt=%b din=%h required %b %h", k, gnt, m_din, 4'b0001 << idx, 8'h20 + 8'(idx * 17));
      end
      if (k > 0) begin
        n_tests++;
        if (gap < 1) begin n_fail++; $display("FAIL rr_gap%0d: idle cycles=%0d required >=1", k, gap); end
      end
      wait_done(ok);
      e = sb_q.pop_front();
      n_tests++;
      if (!ok || done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
        n_fail++;
        $display("FAIL rr_done%0d: done=%b rx=%h required %b %h", k, done, rx_data, 4'b0001 << e.idx, e.rx);
      end
    end
    step();
    req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_modes();
    bit         ok;
    int         cyc;
    exp_t       e;
    int         t_idx  [3] = '{1, 2, 3};
    logic [1:0] t_mode [3] = '{2'b01, 2'b11, 2'b10};
    logic [7:0] t_byte [3] = '{8'hC3, 8'hC3, 8'h5A};
    for (int t = 0; t < 3; t++) begin
      step();
      req_din[t_idx[t]*8 +: 8]  = 8'h81 + 8'(t);
      req_mode[t_idx[t]*2 +: 2] = t_mode[t];
      slave_fixed = 1'b1; slave_byte = t_byte[t];
      req = 4'b0001 << t_idx[t];
      sb_q.push_back('{t_idx[t], t_byte[t]});
      wait_gnt(ok, cyc);
      n_tests++;
      if (!ok || gnt !== (4'b0001 << t_idx[t]) || m_mode !== t_mode[t]) begin
        n_fail++;
        $display("FAIL mode%0d_grant: gnt=%b mode=%b required %b %b", t, gnt, m_mode, 4'b0001 << t_idx[t], t_mode[t]);
      end
      wait_done(ok);
      e = sb_q.pop_front();
      n_tests++;
      if (!ok || done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
        n_fail++;
        $display("FAIL mode%0d_rx: done=%b rx=%h required %b %h", t, done, rx_data, 4'b0001 << e.idx, e.rx);
      end
      step();
      req = 4'b0000;
      repeat (2) step();
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    bit   saw_done;
    exp_t e;
    step();
    req_din[23:16] = 8'h77; req_mode[5:4] = 2'b00; slave_fixed = 1'b0;
    req = 4'b0100;
    wait_ss_low(ok);
    repeat (4) @(negedge clk);
    n_tests++;
    if (!ok || gnt !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_xfer: gnt=%b required 0100", gnt); end
    step();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || m_start !== 1'b0 || done !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_clear: gnt=%b busy=%b start=%b done=%b required 0000 0 0 0000", gnt, busy, m_start, done);
    end
    step();
    reset = 1'b1; req = 4'b0000;
    saw_done = 1'b0; ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done !== 4'b0000) saw_done = 1'b1;
      if (master_busy === 1'b0) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (saw_done || !ok) begin
      n_fail++; $display("FAIL rst_mid_no_done: done_seen=%0d master_idle=%0d required 0 1", saw_done, ok);
    end
    step();
    req_din[7:0] = 8'h4B;
    req = 4'b0101;
    sb_q.push_back('{0, ~8'h4B});
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_rrptr: gnt=%b required 0001", gnt); end
    wait_done(ok);
    e = sb_q.pop_front();
    n_tests++;
    if (!ok || done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
      n_fail++; $display("FAIL rst_mid_after: done=%b rx=%h required %b %h", done, rx_data, 4'b0001 << e.idx, e.rx);
    end
    step();
    req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_req_drop();
    bit   ok;
    exp_t e;
    step();
    req_din[7:0] = 8'hE1; req_mode[1:0] = 2'b01;
    slave_fixed = 1'b1; slave_byte = 8'h96;
    req = 4'b0001;
    sb_q.push_back('{0, 8'h96});
    wait_ss_low(ok);
    repeat (3) @(negedge clk);
    step();
    req = 4'b0000;
    wait_done(ok);
    e = sb_q.pop_front();
    n_tests++;
    if (!ok || done !== (4'b0001 << e.idx) || rx_data !== e.rx || err !== 4'b0000) begin
      n_fail++;
      $display("FAIL req_drop_done: done=%b rx=%h err=%b required %b %h 0000", done, rx_data, err, 4'b0001 << e.idx, e.rx);
    end
    repeat (3) step();
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cyc;
    int c;
    master_hold = 1'b1;
    step();
    req_din[7:0] = 8'h11; req_mode[1:0] = 2'b00;
    req = 4'b0001;
    wait_gnt(ok, cyc);
    c = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      c++;
      if (err !== 4'b0000) break;
    end
    n_tests++;
    if (c != 16 || err !== 4'b0001 || m_start !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_err: cycles=%0d err=%b start=%b gnt=%b required 16 0001 0 0000", c, err, m_start, gnt);
    end
    step();
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy=%b required 0", busy); end
    master_hold = 1'b0;
    repeat (2) step();
  endtask
`endif

  initial begin
    reset = 1'b0; req = '0; req_din = '0; req_mode = '0;
    master_hold = 1'b0; slave_fixed = 1'b0; slave_byte = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_modes();
    test_reset_mid();
    test_req_drop();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: %0d entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one spi_master between NUM_REQ byte-transaction requesters using round-robin arbitration.
- Per granted requester: latches its din/mode, sequences the master's start handshake, and tracks the transaction through SS.
- Shadow-shifts MISO to return the received byte, then signals completion to the winner.
- Sits between the system-side requesters and the spi_master instance; same clock domain as the master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 64, max clk cycles from grant to SS rise before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock; every flop is on its rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
- req  in  NUM_REQ  level request per requester; held until its done/err.
- req_din  in  NUM_REQ*8  tx byte per requester; slice i = [8i+7:8i].
- req_mode  in  NUM_REQ*2  SPI mode per requester; [1]=CPOL, [0]=CPHA.
- gnt  out  NUM_REQ  one-hot grant, high for the whole transaction.
- done  out  NUM_REQ  1-cycle pulse on the granted bit at normal completion.
- err  out  NUM_REQ  1-cycle pulse on timeout abort (stays 0 without the optional feature).
- rx_data  out  8  received byte; valid in the done cycle and held until the next grant.
- busy  out  1  high whenever state != IDLE.
- m_start  out  1  drives spi_master start.
- m_din  out  8  drives spi_master din.
- m_mode  out  2  drives spi_master mode.
- m_ss  in  1  spi_master SS.
- m_sclk  in  1  spi_master SCLK.
- m_miso  in  1  MISO line, same net the master samples.

Behaviour:
- Reset values: gnt=0, done=0, err=0, rx_data=0, busy=0, m_start=0, m_din=0, m_mode=0, state=IDLE, rr_ptr=NUM_REQ-1, bit_cnt=0.
- States: IDLE, START, XFER, FIN, GAP.
- IDLE:
  - If any req bit is set, pick the first set bit searching rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: gnt=onehot(winner), m_din/m_mode latched from the winner's slices, rr_ptr=winner, m_start=1, state→START.
  - Arbitration latency: 1 cycle from req high to gnt.
- START:
  - Hold m_start=1 until m_ss==0 is sampled.
  - In that cycle: m_start→0, bit_cnt=0, state→XFER.
  - m_start must be low before the master returns to idle, so a second transaction is never launched.
- XFER:
  - Keep prev_sclk (m_sclk registered). Leading edge = m_sclk != prev_sclk and prev_sclk == m_mode[1]. Trailing edge = m_sclk != prev_sclk and prev_sclk != m_mode[1].
  - Sample edge: leading if m_mode[0]==0, trailing if m_mode[0]==1.
  - On each sample edge with bit_cnt<8: shreg={m_miso, shreg[7:1]} (LSB-first, matching the master's shift direction), bit_cnt+1. Edges after 8 samples are ignored.
  - m_ss==1 sampled → state→FIN.
- FIN:
  - Single cycle: rx_data=shreg, done[winner]=1, gnt=0, state→GAP.
  - If fewer than 8 bits were sampled, rx_data is still shreg as-is; this is not an error.
- GAP:
  - Single idle cycle, then IDLE; minimum 1 cycle between transactions.
  - The previous winner may re-win only if no other req is set.
- m_din/m_mode are stable from grant through FIN.
- req dropping while granted is ignored; the transaction completes and done still pulses.
- reset==0 mid-transaction clears everything to reset values next edge; no done/err is emitted.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears at grant and increments in START/XFER.
  - Reaching TIMEOUT_CYC-1 without m_ss rising → m_start=0, err[winner]=1 pulse, gnt=0, rx_data unchanged, state→GAP.
  - Timeout beats an m_ss rise sampled in the same cycle.
- Undefined: no counter, err tied to 0, the block waits indefinitely.

Test Plan:
- req=4'b0001, req_din[7:0]=8'hA5, mode=0, slave returns 8'h3C → gnt=0001 one cycle after req; m_din=A5; m_start drops on SS fall; done[0] pulses after SS rise; rx_data=8'h3C.
- req=4'b1111 held, each re-asserting after its done → grant order 0,1,2,3,0; each gnt exactly one-hot; at least 1 GAP cycle between grants.
- Requesters 1 and 2 with modes 2'b01 and 2'b11, slave byte 8'hC3 → rx_data=8'hC3 for both, confirming CPHA/CPOL sample-edge selection.
- reset driven 0 during XFER of requester 2 → next edge gnt=0, busy=0, m_start=0, no done; after release req0 wins first (rr_ptr=NUM_REQ-1).
- req0 dropped mid-XFER → transaction completes and done[0] still pulses.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, master held so SS never falls → err[winner] pulses 16 cycles after grant; m_start=0; block back in IDLE 2 cycles later.
